// File: rtl/ks_add_scheduler_if.sv
// ---------------------------------------------------------------------------
// ks_add_scheduler_if
//   Bundles the two request channels, the shared 8-bit adder-slice pins and
//   the response channel of ks_add_scheduler.
//   Optional macro: KS_SCHED_OVF_EN adds the rsp_ovf signal.
//
//   master modport : the scheduler (drives ready, adder operands, response)
//   slave modport  : the surrounding logic (requesters, adder slice, consumer)
//
//   Signals:
//     reqN_valid/ready  request handshake for requester N
//     reqN_a/b/cin      operands and carry-in for requester N (W bits)
//     add_a/b/cin       operand bytes and carry-in to the adder slice
//     add_sum/cout      combinational slice result
//     rsp_valid/ready   response handshake
//     rsp_id/sum/cout   requester index, full sum, final carry
//     rsp_ovf           signed overflow (only with KS_SCHED_OVF_EN)
// ---------------------------------------------------------------------------
interface ks_add_scheduler_if #(
  parameter int WORD_BYTES = 4
) ();
  localparam int W = 8 * WORD_BYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
`ifdef KS_SCHED_OVF_EN
  logic         rsp_ovf;
`endif

  modport master (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  add_sum, add_cout, rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef KS_SCHED_OVF_EN
    , output rsp_ovf
`endif
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output add_sum, add_cout, rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef KS_SCHED_OVF_EN
    , input rsp_ovf
`endif
  );
endinterface

// File: rtl/ks_add_scheduler.sv
// ---------------------------------------------------------------------------
// ks_add_scheduler
//   Round-robin scheduler sharing one combinational 8-bit adder slice between
//   two requesters. A granted request is added LSB byte first, one byte per
//   cycle, with the carry chained through a register; the full-width result
//   is returned over a valid/ready response channel.
//   Optional macro: KS_SCHED_OVF_EN adds rsp_ovf (signed overflow flag).
//
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     bus     ks_add_scheduler_if.master (requests, adder slice, response)
//     busy_o  out  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module ks_add_scheduler #(
  parameter int WORD_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ks_add_scheduler_if.master  bus,
  output logic                busy_o
);
  localparam int W    = 8 * WORD_BYTES;
  localparam int IDXW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;

  logic            grant_any;
  logic            grant_id;
  logic            ready0;
  logic            ready1;
  logic [7:0]      slice_a;
  logic [7:0]      slice_b;
  logic            slice_cin;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state logic, arbitration and adder-slice sequencing.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    slice_a   = 8'd0;
    slice_b   = 8'd0;
    slice_cin = 1'b0;
    grant_any = bus.req0_valid | bus.req1_valid;

    // The round-robin pointer only matters when both requesters contend.
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = rr_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          ready0  = ~grant_id;
          ready1  = grant_id;
          a_d     = grant_id ? bus.req1_a   : bus.req0_a;
          b_d     = grant_id ? bus.req1_b   : bus.req0_b;
          carry_d = grant_id ? bus.req1_cin : bus.req0_cin;
          id_d    = grant_id;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        slice_a   = a_q[{idx_q, 3'b000} +: 8];
        slice_b   = b_q[{idx_q, 3'b000} +: 8];
        slice_cin = carry_q;
        sum_d[{idx_q, 3'b000} +: 8] = bus.add_sum;
        carry_d   = bus.add_cout;
        // idx stays on the last byte in DONE; it is cleared on the next grant.
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          rr_d    = ~id_q;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.add_a      = slice_a;
  assign bus.add_b      = slice_b;
  assign bus.add_cin    = slice_cin;

  // Response fields come straight from registers, so they stay stable in DONE.
  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = carry_q;
  assign busy_o         = (state_q != ST_IDLE);

`ifdef KS_SCHED_OVF_EN
  // Signed overflow: like-signed operands producing a sum of the other sign.
  assign bus.rsp_ovf = (state_q == ST_DONE) &&
                       (a_q[W-1] == b_q[W-1]) &&
                       (sum_q[W-1] != a_q[W-1]);
`endif

endmodule
